lut_digit_serial_mult: RTL and testbench

//   Digit-serial unsigned WIDTH x WIDTH multiplier built on the 2x2 LUT multiplier.
//   It splits both operands into 2-bit digits and issues one digit pair per cycle to a
//   2x2 LUT instance. Each 4-bit partial product is shifted into place and accumulated.

---
 rtl/lut_mult_pkg.sv | 23 ++
 rtl/mult2x2_lut.sv | 33 +++
 rtl/lut_digit_serial_mult.sv | 109 ++++++++++
 tb/tb_lut_digit_serial_mult.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_mult_pkg.sv
// Shared types and sizing helpers for the
// digit-serial LUT multiplier.
package lut_mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int PP_W = 4;

  function automatic int ndig(input int w);
    return w / 2;
  endfunction

  function automatic int cnt_w(input int w);
    int n;
    n = w / 2;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult2x2_lut.sv
// Combinational 2-bit x 2-bit unsigned
// multiplier implemented as a lookup table.
module mult2x2_lut
  import lut_mult_pkg::*;
(
  input  logic [1:0]      i_a,
  input  logic [1:0]      i_b,
  output logic [PP_W-1:0] o_p
);

  always_comb begin
    o_p = '0;
    unique case ({i_a, i_b})
      4'b00_00: o_p = 4'd0;
      4'b00_01: o_p = 4'd0;
      4'b00_10: o_p = 4'd0;
      4'b00_11: o_p = 4'd0;
      4'b01_00: o_p = 4'd0;
      4'b01_01: o_p = 4'd1;
      4'b01_10: o_p = 4'd2;
      4'b01_11: o_p = 4'd3;
      4'b10_00: o_p = 4'd0;
      4'b10_01: o_p = 4'd2;
      4'b10_10: o_p = 4'd4;
      4'b10_11: o_p = 4'd6;
      4'b11_00: o_p = 4'd0;
      4'b11_01: o_p = 4'd3;
      4'b11_10: o_p = 4'd6;
      4'b11_11: o_p = 4'd9;
    endcase
  end

endmodule

// File: rtl/lut_digit_serial_mult.sv
// Digit-serial WIDTH x WIDTH unsigned multiplier
// that walks all digit pairs through one 2x2 LUT.
module lut_digit_serial_mult
  import lut_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int NDIG = ndig(WIDTH);
  localparam int CW   = cnt_w(WIDTH);
  localparam int AW   = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [AW-1:0]    r_acc;
  logic [CW-1:0]    r_i;
  logic [CW-1:0]    r_j;

  logic             w_accept;
  logic             w_last;
  logic [1:0]       w_da;
  logic [1:0]       w_db;
  logic [PP_W-1:0]  w_pp;
  logic [CW:0]      w_sum;
  logic [CW+1:0]    w_sh;
  logic [AW-1:0]    w_ext;
  logic [AW-1:0]    w_term;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_i == LAST) && (r_j == LAST);

  // Shifts rather than indexed selects keep the
  // digit mux legal for every even WIDTH.
  assign w_da = 2'(r_a >> {r_i, 1'b0});
  assign w_db = 2'(r_b >> {r_j, 1'b0});

  mult2x2_lut u_lut (
    .i_a (w_da),
    .i_b (w_db),
    .o_p (w_pp)
  );

  assign w_sum  = {1'b0, r_i} + {1'b0, r_j};
  assign w_sh   = {w_sum, 1'b0};
  assign w_ext  = AW'(w_pp);
  assign w_term = w_ext << w_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next = RUN;
      RUN:  if (w_last) w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_i   <= '0;
      r_j   <= '0;
    end else if (w_accept) begin
      r_a   <= in_a;
      r_b   <= in_b;
      r_acc <= '0;
      r_i   <= '0;
      r_j   <= '0;
    end else if (r_state == RUN) begin
      r_acc <= r_acc + w_term;
      if (r_j == LAST) begin
        r_j <= '0;
        r_i <= r_i + 1'b1;
      end else begin
        r_j <= r_j + 1'b1;
      end
    end
  end

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_p     = r_acc;

endmodule

// File: tb/tb_lut_digit_serial_mult.sv
// Self-checking bench for lut_digit_serial_mult
// at WIDTH=8 and WIDTH=2 against plain a*b.
module tb_lut_digit_serial_mult;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        iv8 = 1'b0;
  logic        ir8;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        ov8;
  logic        or8 = 1'b0;
  logic [15:0] p8;
  logic        busy8;

  logic        iv2 = 1'b0;
  logic        ir2;
  logic [1:0]  a2 = '0;
  logic [1:0]  b2 = '0;
  logic        ov2;
  logic        or2 = 1'b0;
  logic [3:0]  p2;
  logic        busy2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  lut_digit_serial_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .in_a(a8), .in_b(b8),
    .out_valid(ov8), .out_ready(or8),
    .out_p(p8), .busy(busy8)
  );

  lut_digit_serial_mult #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(iv2), .in_ready(ir2),
    .in_a(a2), .in_b(b2),
    .out_valid(ov2), .out_ready(or2),
    .out_p(p2), .busy(busy2)
  );

  // Drives one operand pair; returns at #1 after the
  // edge where out_valid first rises (or on timeout).
  task automatic do_op8(input logic [7:0] a,
                        input logic [7:0] b,
                        output logic [15:0] p,
                        output int lat);
    int n;
    a8 = a;
    b8 = b;
    iv8 = 1'b1;
    n = 0;
    while (!ir8 && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    p = p8;
  endtask

  task automatic do_op2(input logic [1:0] a,
                        input logic [1:0] b,
                        output logic [3:0] p,
                        output int lat);
    int n;
    a2 = a;
    b2 = b;
    iv2 = 1'b1;
    n = 0;
    while (!ir2 && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    iv2 = 1'b0;
    lat = 0;
    while (!ov2 && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    p = p2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({ir8, ov8, busy8} !== 3'b000 || p8 !== 16'd0) begin
      $display("FAIL reset_state: ir=%b ov=%b busy=%b p=%0d want 0 0 0 0",
               ir8, ov8, busy8, p8);
    end else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (ir8 !== 1'b1 || ir2 !== 1'b1) begin
      $display("FAIL reset_release: ir8=%b ir2=%b want 1 1", ir8, ir2);
    end else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [15:0] p;
    int lat;
    or8 = 1'b1;
    do_op8(8'd3, 8'd3, p, lat);
    total_cnt++;
    if (lat !== 16 || p !== 16'd9) begin
      $display("FAIL basic_3x3: lat=%0d p=%0d want 16 9", lat, p);
    end else pass_cnt++;
    total_cnt++;
    if (ir8 !== 1'b0 || busy8 !== 1'b1) begin
      $display("FAIL basic_done_flags: ir=%b busy=%b want 0 1", ir8, busy8);
    end else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1 || busy8 !== 1'b0) begin
      $display("FAIL basic_idle: ov=%b ir=%b busy=%b want 0 1 0",
               ov8, ir8, busy8);
    end else pass_cnt++;
  endtask

  task automatic test_corners();
    logic [15:0] p;
    int lat;
    or8 = 1'b1;
    do_op8(8'd255, 8'd255, p, lat);
    total_cnt++;
    if (lat !== 16 || p !== 16'hFE01) begin
      $display("FAIL max_operands: lat=%0d p=%h want 16 fe01", lat, p);
    end else pass_cnt++;
    @(posedge clk); #1;
    do_op8(8'd0, 8'd200, p, lat);
    total_cnt++;
    if (lat !== 16 || p !== 16'd0) begin
      $display("FAIL zero_operand: lat=%0d p=%0d want 16 0", lat, p);
    end else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [15:0] p;
    int lat;
    bit ok;
    or8 = 1'b0;
    do_op8(8'd123, 8'd45, p, lat);
    total_cnt++;
    if (lat !== 16 || p !== 16'(123 * 45)) begin
      $display("FAIL bp_result: lat=%0d p=%0d want 16 %0d", lat, p, 123 * 45);
    end else pass_cnt++;
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (ov8 !== 1'b1 || p8 !== 16'(123 * 45) || ir8 !== 1'b0) ok = 1'b0;
    end
    total_cnt++;
    if (!ok) begin
      $display("FAIL bp_hold: ov=%b p=%0d ir=%b want 1 %0d 0",
               ov8, p8, ir8, 123 * 45);
    end else pass_cnt++;
    or8 = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      $display("FAIL bp_release: ov=%b ir=%b want 0 1", ov8, ir8);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] p;
    int lat;
    bit seen;
    or8 = 1'b1;
    a8 = 8'd201;
    b8 = 8'd177;
    iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (ov8 !== 1'b0 || busy8 !== 1'b0 || p8 !== 16'd0 || ir8 !== 1'b0) begin
      $display("FAIL mid_reset: ov=%b busy=%b p=%0d ir=%b want 0 0 0 0",
               ov8, busy8, p8, ir8);
    end else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (ov8 === 1'b1) seen = 1'b1;
    end
    total_cnt++;
    if (seen) begin
      $display("FAIL mid_reset_no_valid: out_valid rose=1 want 0");
    end else pass_cnt++;
    do_op8(8'd17, 8'd12, p, lat);
    total_cnt++;
    if (lat !== 16 || p !== 16'd204) begin
      $display("FAIL post_reset_op: lat=%0d p=%0d want 16 204", lat, p);
    end else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_busy();
    int lat;
    or8 = 1'b1;
    a8 = 8'd100;
    b8 = 8'd37;
    iv8 = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!ov8 && lat < TMO) begin
      iv8 = 1'($urandom);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    iv8 = 1'b0;
    total_cnt++;
    if (lat !== 16 || p8 !== 16'd3700) begin
      $display("FAIL ignore_busy: lat=%0d p=%0d want 16 3700", lat, p8);
    end else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_width2();
    logic [3:0] p;
    int lat;
    int exp;
    or2 = 1'b1;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        do_op2(2'(a), 2'(b), p, lat);
        exp = a * b;
        total_cnt++;
        if (lat !== 1 || p !== 4'(exp)) begin
          $display("FAIL w2_%0dx%0d: lat=%0d p=%0d want 1 %0d",
                   a, b, lat, p, exp);
        end else pass_cnt++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [15:0] p;
    logic [7:0] a;
    logic [7:0] b;
    int lat;
    int unsigned exp;
    or8 = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      exp = int'(a) * int'(b);
      do_op8(a, b, p, lat);
      total_cnt++;
      if (lat !== 16 || p !== 16'(exp)) begin
        $display("FAIL rand_%0d: a=%0d b=%0d lat=%0d p=%0d want 16 %0d",
                 k, a, b, lat, p, exp);
      end else pass_cnt++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_ignore_busy();
    test_width2();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
